// File: rtl/micro_seq_pkg.sv
// Shared definitions for the microprogram sequencer.
//   - NextSel encodings of the control word's sequencing field
//   - sequencer state encodings (legacy-compatible localparam constants)
//   - default control-store address of the fetch routine
package micro_seq_pkg;

    // Sequencing field of the control word
    localparam logic [1:0] SEL_INC   = 2'b00;
    localparam logic [1:0] SEL_IB    = 2'b01;
    localparam logic [1:0] SEL_SB    = 2'b10;
    localparam logic [1:0] SEL_FETCH = 2'b11;

    // Sequencer states
    typedef logic [1:0] seq_state_t;
    localparam seq_state_t ST_HOLD = 2'd0;
    localparam seq_state_t ST_RUN  = 2'd1;
    localparam seq_state_t ST_WAIT = 2'd2;

    localparam int unsigned DEFAULT_FETCH_ADDR = 0;

endpackage

// File: rtl/micro_next_addr.sv
// Combinational next-address generator for the micro-sequencer.
// Selects among increment, conditional skip (+2), IB dispatch, SB dispatch and
// the fetch address. wrap flags an INC/skip that carried out of the uPC width.
// Ports:
//   upc        current control-store address
//   next_sel   sequencing field (SEL_*)
//   cond_skip  skip requested on a zero test
//   zero_flag  registered ALU zero flag
//   ib_addr    decoder instruction-branch address
//   sb_addr    decoder secondary-branch address
//   next_addr  selected next address
//   wrap       increment/skip wrapped modulo 2^ADDR_W
module micro_next_addr
    import micro_seq_pkg::*;
#(
    parameter int unsigned ADDR_W     = 6,
    parameter int unsigned FETCH_ADDR = DEFAULT_FETCH_ADDR
) (
    input  logic [ADDR_W-1:0] upc,
    input  logic [1:0]        next_sel,
    input  logic              cond_skip,
    input  logic              zero_flag,
    input  logic [ADDR_W-1:0] ib_addr,
    input  logic [ADDR_W-1:0] sb_addr,
    output logic [ADDR_W-1:0] next_addr,
    output logic              wrap
);

    logic [ADDR_W:0] inc_sum;
    logic [ADDR_W:0] step;

    // Skip taken when the tested value is non-zero
    always_comb begin
        step = (cond_skip && !zero_flag) ? (ADDR_W+1)'(2) : (ADDR_W+1)'(1);
        inc_sum = {1'b0, upc} + step;
    end

    always_comb begin
        next_addr = upc;
        wrap      = 1'b0;
        case (next_sel)
            SEL_INC: begin
                next_addr = inc_sum[ADDR_W-1:0];
                wrap      = inc_sum[ADDR_W];
            end
            SEL_IB:    next_addr = ib_addr;
            SEL_SB:    next_addr = sb_addr;
            SEL_FETCH: next_addr = ADDR_W'(FETCH_ADDR);
            default:   next_addr = upc;
        endcase
    end

endmodule

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: owns the control-store address register (uPC).
// Optional feature macro: SEQ_STALL_EN enables memory stalls (MemAccess &
// !MemReady freezes uPC, state and wait counter). Without it the memory
// inputs are ignored and Stalled stays 0.
// Ports:
//   ClockInput   rising-edge clock
//   ResetInput   synchronous, active-high reset
//   IB_Address   decoder instruction-branch address
//   SB_Address   decoder secondary-branch address
//   NextSel      sequencing field of the current control word
//   CondSkip     current word requests a skip on a zero test
//   ZeroFlag     registered ALU zero flag
//   MemAccess    current word performs a memory access
//   MemReady     memory completes the access this cycle
//   uPC          control-store address (registered)
//   InstrStart   pulse aligned with uPC loaded from IB_Address
//   Stalled      uPC held for memory this cycle
//   SeqError     sticky increment-wrap error
module micro_sequencer
    import micro_seq_pkg::*;
#(
    parameter int unsigned ADDR_W     = 6,
    parameter int unsigned FETCH_ADDR = DEFAULT_FETCH_ADDR,
    parameter int unsigned IB_WAIT    = 1
) (
    input  logic              ClockInput,
    input  logic              ResetInput,
    input  logic [ADDR_W-1:0] IB_Address,
    input  logic [ADDR_W-1:0] SB_Address,
    input  logic [1:0]        NextSel,
    input  logic              CondSkip,
    input  logic              ZeroFlag,
    input  logic              MemAccess,
    input  logic              MemReady,
    output logic [ADDR_W-1:0] uPC,
    output logic              InstrStart,
    output logic              Stalled,
    output logic              SeqError
);

    // Counter reload value; only used when IB_WAIT > 0
    localparam logic [1:0] WAIT_LOAD = (IB_WAIT == 0) ? 2'd0 : 2'(IB_WAIT - 1);
    localparam logic [ADDR_W-1:0] FETCH_A = ADDR_W'(FETCH_ADDR);

    seq_state_t        state_q, state_d;
    logic [ADDR_W-1:0] upc_q, upc_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              instr_start_q, instr_start_d;
    logic              stalled_q, stalled_d;
    logic              seq_error_q, seq_error_d;

    logic [ADDR_W-1:0] next_addr;
    logic              wrap;
    logic              stall;

`ifdef SEQ_STALL_EN
    assign stall = MemAccess & ~MemReady;
`else
    logic unused_mem;
    assign unused_mem = MemAccess ^ MemReady;
    assign stall      = 1'b0;
`endif

    micro_next_addr #(
        .ADDR_W     (ADDR_W),
        .FETCH_ADDR (FETCH_ADDR)
    ) u_next_addr (
        .upc       (upc_q),
        .next_sel  (NextSel),
        .cond_skip (CondSkip),
        .zero_flag (ZeroFlag),
        .ib_addr   (IB_Address),
        .sb_addr   (SB_Address),
        .next_addr (next_addr),
        .wrap      (wrap)
    );

    always_comb begin
        state_d       = state_q;
        upc_d         = upc_q;
        cnt_d         = cnt_q;
        instr_start_d = 1'b0;
        stalled_d     = 1'b0;
        seq_error_d   = seq_error_q;
        case (state_q)
            ST_HOLD: begin
                upc_d   = FETCH_A;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (stall) begin
                    stalled_d = 1'b1;
                end else if (NextSel == SEL_IB && IB_WAIT != 0) begin
                    // uPC holds while the decoder's IB output settles
                    state_d = ST_WAIT;
                    cnt_d   = WAIT_LOAD;
                end else begin
                    upc_d         = next_addr;
                    seq_error_d   = seq_error_q | wrap;
                    instr_start_d = (NextSel == SEL_IB);
                end
            end
            ST_WAIT: begin
                if (stall) begin
                    stalled_d = 1'b1;
                end else if (cnt_q == 2'd0) begin
                    upc_d         = IB_Address;
                    instr_start_d = 1'b1;
                    state_d       = ST_RUN;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            default: begin
                state_d = ST_HOLD;
                upc_d   = FETCH_A;
            end
        endcase
    end

    always_ff @(posedge ClockInput) begin
        if (ResetInput) begin
            state_q       <= ST_HOLD;
            upc_q         <= FETCH_A;
            cnt_q         <= 2'd0;
            instr_start_q <= 1'b0;
            stalled_q     <= 1'b0;
            seq_error_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            upc_q         <= upc_d;
            cnt_q         <= cnt_d;
            instr_start_q <= instr_start_d;
            stalled_q     <= stalled_d;
            seq_error_q   <= seq_error_d;
        end
    end

    assign uPC        = upc_q;
    assign InstrStart = instr_start_q;
    assign Stalled    = stalled_q;
    assign SeqError   = seq_error_q;

endmodule

// File: tb/tb_micro_sequencer.sv
module tb_micro_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] ib_addr;
    logic [5:0] sb_addr;
    logic [1:0] next_sel;
    logic       cond_skip;
    logic       zero_flag;
    logic       mem_access;
    logic       mem_ready;
    logic [5:0] upc;
    logic       instr_start;
    logic       stalled;
    logic       seq_error;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    micro_sequencer #(
        .ADDR_W     (6),
        .FETCH_ADDR (0),
        .IB_WAIT    (1)
    ) dut (
        .ClockInput (clk),
        .ResetInput (rst),
        .IB_Address (ib_addr),
        .SB_Address (sb_addr),
        .NextSel    (next_sel),
        .CondSkip   (cond_skip),
        .ZeroFlag   (zero_flag),
        .MemAccess  (mem_access),
        .MemReady   (mem_ready),
        .uPC        (upc),
        .InstrStart (instr_start),
        .Stalled    (stalled),
        .SeqError   (seq_error)
    );

    typedef struct {
        logic       rst;
        logic [1:0] sel;
        logic       skip;
        logic       zero;
        logic [5:0] ib;
        logic [5:0] sb;
        logic [5:0] exp_upc;
        logic       exp_is;
        logic       exp_err;
    } vec_t;

    vec_t vecs[25];

    task automatic check(input string name, input int idx, input logic [5:0] exp_upc,
                         input logic exp_is, input logic exp_st, input logic exp_err);
        checks++;
        if (upc !== exp_upc || instr_start !== exp_is || stalled !== exp_st ||
            seq_error !== exp_err) begin
            failures++;
            $display("FAIL %s[%0d]: got uPC=%0d InstrStart=%b Stalled=%b SeqError=%b, want uPC=%0d InstrStart=%b Stalled=%b SeqError=%b",
                     name, idx, upc, instr_start, stalled, seq_error,
                     exp_upc, exp_is, exp_st, exp_err);
        end
    endtask

    task automatic drive(input logic r, input logic [1:0] sel, input logic skip,
                         input logic zero, input logic [5:0] ib, input logic [5:0] sb,
                         input logic ma, input logic mr);
        rst        = r;
        next_sel   = sel;
        cond_skip  = skip;
        zero_flag  = zero;
        ib_addr    = ib;
        sb_addr    = sb;
        mem_access = ma;
        mem_ready  = mr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // rst sel skip zero ib sb | uPC InstrStart SeqError
        vecs[0]  = '{1'b1, 2'b00, 1'b0, 1'b0, 6'd0,  6'd0,  6'd0,  1'b0, 1'b0}; // reset
        vecs[1]  = '{1'b0, 2'b00, 1'b0, 1'b0, 6'd0,  6'd0,  6'd0,  1'b0, 1'b0}; // HOLD
        vecs[2]  = '{1'b0, 2'b00, 1'b0, 1'b0, 6'd0,  6'd0,  6'd1,  1'b0, 1'b0};
        vecs[3]  = '{1'b0, 2'b00, 1'b0, 1'b0, 6'd0,  6'd0,  6'd2,  1'b0, 1'b0};
        vecs[4]  = '{1'b0, 2'b00, 1'b0, 1'b0, 6'd0,  6'd0,  6'd3,  1'b0, 1'b0};
        vecs[5]  = '{1'b0, 2'b00, 1'b0, 1'b0, 6'd0,  6'd0,  6'd4,  1'b0, 1'b0};
        vecs[6]  = '{1'b0, 2'b01, 1'b0, 1'b0, 6'd15, 6'd0,  6'd4,  1'b0, 1'b0}; // -> WAIT
        vecs[7]  = '{1'b0, 2'b11, 1'b0, 1'b0, 6'd15, 6'd0,  6'd15, 1'b1, 1'b0}; // sel ignored
        vecs[8]  = '{1'b0, 2'b00, 1'b0, 1'b0, 6'd15, 6'd0,  6'd16, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 2'b10, 1'b0, 1'b0, 6'd0,  6'd11, 6'd11, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 2'b00, 1'b1, 1'b0, 6'd0,  6'd0,  6'd13, 1'b0, 1'b0}; // skip
        vecs[11] = '{1'b0, 2'b10, 1'b0, 1'b0, 6'd0,  6'd11, 6'd11, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 2'b00, 1'b1, 1'b1, 6'd0,  6'd0,  6'd12, 1'b0, 1'b0}; // no skip
        vecs[13] = '{1'b0, 2'b10, 1'b1, 1'b0, 6'd0,  6'd20, 6'd20, 1'b0, 1'b0}; // skip ignored
        vecs[14] = '{1'b0, 2'b11, 1'b0, 1'b0, 6'd0,  6'd0,  6'd0,  1'b0, 1'b0};
        vecs[15] = '{1'b0, 2'b10, 1'b0, 1'b0, 6'd0,  6'd63, 6'd63, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 2'b00, 1'b0, 1'b0, 6'd0,  6'd0,  6'd0,  1'b0, 1'b1}; // wrap
        vecs[17] = '{1'b0, 2'b11, 1'b0, 1'b0, 6'd0,  6'd0,  6'd0,  1'b0, 1'b1};
        vecs[18] = '{1'b0, 2'b10, 1'b0, 1'b0, 6'd0,  6'd21, 6'd21, 1'b0, 1'b1};
        vecs[19] = '{1'b0, 2'b01, 1'b0, 1'b0, 6'd25, 6'd0,  6'd21, 1'b0, 1'b1}; // -> WAIT
        vecs[20] = '{1'b1, 2'b00, 1'b0, 1'b0, 6'd25, 6'd0,  6'd0,  1'b0, 1'b0}; // abort
        vecs[21] = '{1'b0, 2'b00, 1'b0, 1'b0, 6'd25, 6'd0,  6'd0,  1'b0, 1'b0}; // HOLD
        vecs[22] = '{1'b0, 2'b10, 1'b0, 1'b0, 6'd0,  6'd62, 6'd62, 1'b0, 1'b0};
        vecs[23] = '{1'b0, 2'b00, 1'b1, 1'b0, 6'd0,  6'd0,  6'd0,  1'b0, 1'b1}; // skip wrap
        vecs[24] = '{1'b0, 2'b00, 1'b0, 1'b0, 6'd0,  6'd0,  6'd1,  1'b0, 1'b1};

        rst = 1'b1; next_sel = 2'b00; cond_skip = 1'b0; zero_flag = 1'b0;
        ib_addr = '0; sb_addr = '0; mem_access = 1'b0; mem_ready = 1'b1;

        for (int i = 0; i < 25; i++) begin
            drive(vecs[i].rst, vecs[i].sel, vecs[i].skip, vecs[i].zero,
                  vecs[i].ib, vecs[i].sb, 1'b0, 1'b1);
            check("vec", i, vecs[i].exp_upc, vecs[i].exp_is, 1'b0, vecs[i].exp_err);
        end

        // Memory stall during WAIT, then reset mid-stall
        drive(1'b1, 2'b00, 1'b0, 1'b0, 6'd40, 6'd0, 1'b0, 1'b1);
        check("st_rst", 0, 6'd0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 2'b00, 1'b0, 1'b0, 6'd40, 6'd0, 1'b0, 1'b1);
        check("st_hold", 0, 6'd0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 2'b01, 1'b0, 1'b0, 6'd40, 6'd0, 1'b0, 1'b1);
        check("st_wait", 0, 6'd0, 1'b0, 1'b0, 1'b0);
`ifdef SEQ_STALL_EN
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 2'b00, 1'b0, 1'b0, 6'd40, 6'd0, 1'b1, 1'b0);
            check("stall_wait", i, 6'd0, 1'b0, 1'b1, 1'b0);
        end
        drive(1'b0, 2'b00, 1'b0, 1'b0, 6'd40, 6'd0, 1'b1, 1'b1);
        check("stall_done", 0, 6'd40, 1'b1, 1'b0, 1'b0);
        // Stall in RUN freezes INC
        drive(1'b0, 2'b00, 1'b0, 1'b0, 6'd40, 6'd0, 1'b1, 1'b0);
        check("stall_run", 0, 6'd40, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 2'b00, 1'b0, 1'b0, 6'd40, 6'd0, 1'b1, 1'b1);
        check("stall_run_done", 0, 6'd41, 1'b0, 1'b0, 1'b0);
        // Reset while stalled in WAIT: no InstrStart afterwards
        drive(1'b0, 2'b01, 1'b0, 1'b0, 6'd50, 6'd0, 1'b0, 1'b1);
        check("st_wait2", 0, 6'd41, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 2'b00, 1'b0, 1'b0, 6'd50, 6'd0, 1'b1, 1'b0);
        check("stall_wait2", 0, 6'd41, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 2'b00, 1'b0, 1'b0, 6'd50, 6'd0, 1'b1, 1'b0);
        check("stall_rst", 0, 6'd0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 2'b00, 1'b0, 1'b0, 6'd50, 6'd0, 1'b0, 1'b1);
        check("stall_rst_hold", 0, 6'd0, 1'b0, 1'b0, 1'b0);
`else
        // Memory inputs ignored: dispatch completes regardless
        drive(1'b0, 2'b00, 1'b0, 1'b0, 6'd40, 6'd0, 1'b1, 1'b0);
        check("nostall_wait", 0, 6'd40, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 2'b00, 1'b0, 1'b0, 6'd40, 6'd0, 1'b1, 1'b0);
        check("nostall_run", 0, 6'd41, 1'b0, 1'b0, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
